// File: rtl/ieeedrv_stepper.sv
// Stepper-phase decoder for the 4040/8250 IEEE drive: tracks head position per sub-drive.
// Optional head-settle counters are built when IEEEDRV_SETTLE_EN is defined.
module ieeedrv_stepper #(
    parameter int          SUBDRV       = 2,
    parameter logic [15:0] SETTLE_TICKS = 16'd3000,
    localparam int         NS           = SUBDRV - 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          drv_type,
    input  logic [NS:0]   drv_mtr,
    input  logic [1:0]    stp      [SUBDRV],
    output logic [6:0]    track    [SUBDRV],
    output logic [NS:0]   tr00,
    output logic [NS:0]   settling,
    output logic [NS:0]   step_err
);

    logic [6:0] maxtrk_s;
    assign maxtrk_s = drv_type ? 7'd34 : 7'd76;

    for (genvar d = 0; d < SUBDRV; d++) begin : g_drv
        logic [1:0] last_ph_q, last_ph_d;
        logic [1:0] delta_s;
        logic [6:0] track_q, track_d;
        logic       step_err_q, step_err_d;
        logic       over_s;

        assign delta_s = stp[d] - last_ph_q;
        assign over_s  = (track_q > maxtrk_s);

        // Next-state for phase memory, track position and the error pulse.
        always_comb begin
            last_ph_d  = last_ph_q;
            track_d    = track_q;
            step_err_d = 1'b0;
            if (ce) begin
                last_ph_d  = stp[d];
                step_err_d = (delta_s == 2'd2);
                // A drive-type change that leaves the head beyond the last track wins over any step.
                if (over_s) begin
                    track_d = maxtrk_s;
                end else if (drv_mtr[d]) begin
                    case (delta_s)
                        2'd1:    track_d = (track_q >= maxtrk_s) ? maxtrk_s : track_q + 7'd1;
                        2'd3:    track_d = (track_q == 7'd0) ? 7'd0 : track_q - 7'd1;
                        default: track_d = track_q;
                    endcase
                end else begin
                    track_d = track_q;
                end
            end else begin
                last_ph_d = last_ph_q;
            end
        end

        // Position and status registers.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                last_ph_q  <= 2'd0;
                track_q    <= 7'd0;
                step_err_q <= 1'b0;
            end else begin
                last_ph_q  <= last_ph_d;
                track_q    <= track_d;
                step_err_q <= step_err_d;
            end
        end

        assign track[d]    = track_q;
        assign tr00[d]     = (track_q == 7'd0);
        assign step_err[d] = step_err_q;

`ifdef IEEEDRV_SETTLE_EN
        logic [15:0] settle_cnt_q, settle_cnt_d;
        logic        accept_s;

        // Clamped steps at either end still count as accepted and restart settling.
        assign accept_s = ce && !over_s && drv_mtr[d] && delta_s[0];

        // Settle counter next-state: reload on accepted step, else count down on ce.
        always_comb begin
            settle_cnt_d = settle_cnt_q;
            if (accept_s) begin
                settle_cnt_d = SETTLE_TICKS;
            end else if (ce && (settle_cnt_q != 16'd0)) begin
                settle_cnt_d = settle_cnt_q - 16'd1;
            end else begin
                settle_cnt_d = settle_cnt_q;
            end
        end

        // Settle counter register.
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                settle_cnt_q <= 16'd0;
            end else begin
                settle_cnt_q <= settle_cnt_d;
            end
        end

        assign settling[d] = (settle_cnt_q != 16'd0);
`else
        assign settling[d] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ieeedrv_stepper.sv
// Directed self-checking bench for ieeedrv_stepper (two sub-drives, short settle time).
module tb_ieeedrv_stepper;

    localparam int          SUBDRV = 2;
    localparam logic [15:0] STK    = 16'd5;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       drv_type;
    logic [1:0] drv_mtr;
    logic [1:0] stp   [SUBDRV];
    logic [6:0] track [SUBDRV];
    logic [1:0] tr00, settling, step_err;
    logic [1:0] ph0, ph1;

    int n_tests = 0;
    int n_fail  = 0;

    ieeedrv_stepper #(.SUBDRV(SUBDRV), .SETTLE_TICKS(STK)) u_dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ce       (ce),
        .drv_type (drv_type),
        .drv_mtr  (drv_mtr),
        .stp      (stp),
        .track    (track),
        .tr00     (tr00),
        .settling (settling),
        .step_err (step_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One ce cycle with the given phases; returns #1 after the sampling edge.
    task automatic tick(input logic [1:0] s0, input logic [1:0] s1);
        @(negedge clk_sys);
        stp[0] = s0;
        stp[1] = s1;
        ce     = 1'b1;
        @(posedge clk_sys);
        #1;
        ce = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        ce       = 1'b0;
        drv_type = 1'b0;
        drv_mtr  = 2'b01;
        stp[0]   = 2'd0;
        stp[1]   = 2'd0;
        ph0      = 2'd0;
        ph1      = 2'd0;
        idle(2);
        check_eq("rst_track0", 32'(track[0]), 32'd0);
        check_eq("rst_track1", 32'(track[1]), 32'd0);
        check_eq("rst_tr00", 32'(tr00), 32'd3);
        check_eq("rst_settling", 32'(settling), 32'd0);
        check_eq("rst_step_err", 32'(step_err), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        idle(2);

        // Inward sequence 1,2,3,0,1: one track per ce, visible right after the edge.
        for (int k = 1; k <= 5; k++) begin
            ph0 = ph0 + 2'd1;
            tick(ph0, ph1);
            check_eq("inward_step", 32'(track[0]), 32'(k));
        end
        check_eq("seq_tr00_0", 32'(tr00[0]), 32'd0);
        check_eq("seq_track1", 32'(track[1]), 32'd0);
        check_eq("seq_tr00_1", 32'(tr00[1]), 32'd1);
        check_eq("seq_err", 32'(step_err), 32'd0);

        // Back out to track 0.
        for (int k = 4; k >= 0; k--) begin
            ph0 = ph0 - 2'd1;
            tick(ph0, ph1);
            check_eq("outward_step", 32'(track[0]), 32'(k));
        end

        // Outward step at track 0: clamped but still accepted.
        ph0 = 2'd3;
        tick(ph0, ph1);
        check_eq("zero_clamp", 32'(track[0]), 32'd0);
        check_eq("zero_tr00", 32'(tr00[0]), 32'd1);
`ifdef IEEEDRV_SETTLE_EN
        check_eq("settle_rise", 32'(settling[0]), 32'd1);
        idle(3);
        check_eq("settle_hold_no_ce", 32'(settling[0]), 32'd1);
        for (int k = 1; k <= int'(STK); k++) begin
            tick(ph0, ph1);
            check_eq("settle_count", 32'(settling[0]), (k < int'(STK)) ? 32'd1 : 32'd0);
        end
        check_eq("settle_other_drive", 32'(settling[1]), 32'd0);
`else
        check_eq("settle_off", 32'(settling), 32'd0);
`endif

        // Run to the last 8250 track, then one more inward step.
        for (int k = 1; k <= 77; k++) begin
            ph0 = ph0 + 2'd1;
            tick(ph0, ph1);
            if (k == 76) check_eq("reach_76", 32'(track[0]), 32'd76);
        end
        check_eq("clamp_76", 32'(track[0]), 32'd76);

        // Switch to 4040: clamp waits for ce and beats a simultaneous outward step.
        @(negedge clk_sys);
        drv_type = 1'b1;
        idle(3);
        check_eq("type_no_ce", 32'(track[0]), 32'd76);
        ph0 = ph0 - 2'd1;
        tick(ph0, ph1);
        check_eq("type_clamp_34", 32'(track[0]), 32'd34);

        // Motor-off phase changes on drive 1 must not move it or cause a step at motor-on.
        ph1 = 2'd1;
        tick(ph0, ph1);
        ph1 = 2'd2;
        tick(ph0, ph1);
        check_eq("mtr_off_track1", 32'(track[1]), 32'd0);
        @(negedge clk_sys);
        drv_mtr = 2'b11;
        tick(ph0, ph1);
        check_eq("mtr_on_no_step", 32'(track[1]), 32'd0);
        ph1 = 2'd3;
        tick(ph0, ph1);
        check_eq("mtr_on_step1", 32'(track[1]), 32'd1);
        check_eq("isolation_track0", 32'(track[0]), 32'd34);

        // Opposite-phase transition: single-clock error pulse, no movement.
        ph0 = ph0 + 2'd2;
        tick(ph0, ph1);
        check_eq("illegal_err", 32'(step_err), 32'd1);
        check_eq("illegal_track", 32'(track[0]), 32'd34);
        idle(1);
        check_eq("illegal_pulse_end", 32'(step_err), 32'd0);

        // Two single-phase moves between ce ticks add up to an illegal delta.
        @(negedge clk_sys);
        stp[0] = ph0 + 2'd1;
        idle(2);
        check_eq("no_ce_ignored", 32'(track[0]), 32'd34);
        check_eq("no_ce_no_err", 32'(step_err), 32'd0);
        ph0 = ph0 + 2'd2;
        tick(ph0, ph1);
        check_eq("net_delta_err", 32'(step_err), 32'd1);
        check_eq("net_delta_track", 32'(track[0]), 32'd34);

        // Simultaneous steps on both drives.
        ph0 = ph0 - 2'd1;
        ph1 = ph1 + 2'd1;
        tick(ph0, ph1);
        check_eq("simul_track0", 32'(track[0]), 32'd33);
        check_eq("simul_track1", 32'(track[1]), 32'd2);

        // Walk drive 0 to track 20, then reset between ce ticks while settling.
        for (int k = 1; k <= 13; k++) begin
            ph0 = ph0 - 2'd1;
            tick(ph0, ph1);
        end
        check_eq("at_track20", 32'(track[0]), 32'd20);
`ifdef IEEEDRV_SETTLE_EN
        check_eq("settling_at_20", 32'(settling[0]), 32'd1);
`endif
        @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_track0", 32'(track[0]), 32'd0);
        check_eq("async_rst_track1", 32'(track[1]), 32'd0);
        check_eq("async_rst_settling", 32'(settling), 32'd0);
        check_eq("async_rst_tr00", 32'(tr00), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ieeedrv_stepper.md
# ieeedrv_stepper

Head-positioning stage for the 4040/8250 IEEE drive: decodes each sub-drive's 2-bit stepper-phase outputs from the drive controller into an absolute 7-bit physical track number. It sits directly upstream of the track loader, which consumes `track[]` to select the disk image region to fetch. It also provides track-zero and head-settling status back to the controller.

## Interface
Parameters:
- `SUBDRV`, 2, number of sub-drives (1 or 2); `NS = SUBDRV-1`
- `SETTLE_TICKS`, 16'd3000, settle time in `ce` ticks after an accepted step

Ports:
- `clk_sys`  in  1  system clock; the only clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `ce`  in  1  drive clock enable; all stepping and timing advance only on `ce` cycles
- `drv_type`  in  1  0 = 8250 (tracks 0..76), 1 = 4040 (tracks 0..34)
- `drv_mtr`  in  NS+1  per-sub-drive spindle motor enable
- `stp`  in  2 × SUBDRV  per-sub-drive stepper phase (array `stp[SUBDRV]`), synchronous to `clk_sys`
- `track`  out  7 × SUBDRV  per-sub-drive current track (array `track[SUBDRV]`)
- `tr00`  out  NS+1  track-zero sensor, 1 when `track[d]==0`
- `settling`  out  NS+1  1 while the head is settling after a step
- `step_err`  out  NS+1  one-clock pulse on an illegal (opposite-phase) transition

## Operation
- Per sub-drive `d`, independent state: `last_ph[d]` (2b), `track[d]` (7b), `settle_cnt[d]` (16b).
- `MAXTRK = drv_type ? 34 : 76`.
- On a `ce` cycle, compute `delta = stp[d] - last_ph[d]` (mod 4):
  - 0: no action.
  - 1: inward step. If `drv_mtr[d]`, `track[d] <= min(track[d]+1, MAXTRK)`.
  - 3: outward step. If `drv_mtr[d]`, `track[d] <= (track[d]==0) ? 0 : track[d]-1`.
  - 2: illegal. No movement; `step_err[d]` pulses for one clock.
  - In all cases `last_ph[d] <= stp[d]`, even with the motor off, so that motor-on never produces a spurious step.
- An accepted step is a motor-on step of delta 1 or 3, including a clamped one at 0 or MAXTRK. An accepted step loads `settle_cnt[d] <= SETTLE_TICKS`. An accepted step during settling reloads the counter.
- `settle_cnt[d]` decrements on `ce` while nonzero. `settling[d] = (settle_cnt[d] != 0)`.
- Clamp on type change: if `track[d] > MAXTRK` (e.g. `drv_type` switched 0→1), then on the next `ce` cycle `track[d] <= MAXTRK` with no settle load. This takes priority over a step in the same cycle.
- `tr00[d]` is combinational from the registered `track[d]`.

## Timing
- `reset_n` low clears asynchronously: `track` = 0, `last_ph` = 0, `settle_cnt` = 0, `tr00` = all 1, `settling` = 0, `step_err` = 0.
- Latency: a `stp` change sampled on a `ce` cycle is reflected in `track` one `clk_sys` edge later. `settling` rises on the same edge.
- Non-`ce` cycles: `stp` changes are ignored until the next `ce`. Only the net delta at that `ce` counts, so a change of 2 between `ce` ticks is an error.
- `step_err` is registered and high exactly one clock, the one following the offending `ce` cycle.
- `settling` falls one clock after the `ce` that decrements the counter to 0, i.e. `SETTLE_TICKS` `ce` ticks after the step.
- Sub-drives never interact. Simultaneous steps on both are both applied.
- Reset asserted mid-settle aborts settling immediately.

## Configuration
- `IEEEDRV_SETTLE_EN` defined: settle counters are built and behave as above.
- Not defined: no counters are synthesised. `settling` is tied to all 0, and `SETTLE_TICKS` is ignored.

## Test plan
- Reset then `drv_type=0`, `drv_mtr[0]=1`, `stp[0]` sequence 1,2,3,0,1 on successive `ce` ticks → `track[0]`=5, `tr00[0]`=0, `track[1]`=0.
- From track 0, `stp[0]` 0→3 → `track[0]` stays 0, `tr00[0]`=1. With `IEEEDRV_SETTLE_EN`, `settling[0]` is high for exactly `SETTLE_TICKS` `ce` ticks.
- Step to 76 with `drv_type=0`, one more inward step → 76. Switch `drv_type=1` → `track[0]`=34 after the next `ce`.
- `drv_mtr[0]=0`, `stp[0]` 0→1→2, then motor on with no phase change → `track[0]` unchanged at 0.
- `stp[0]` 0→2 in one `ce` → `step_err[0]` high for exactly 1 clock, `track[0]` unchanged.
- Pull `reset_n` low between `ce` ticks at track 20 while settling → `track`=0, `settling`=0 before the next clock edge.
